// File: rtl/mult_wb_sched.sv
// mult_wb_sched
// -----------------------------------------------------------------------------
// Issue gate and writeback scheduler for the pipelined multiplier.
//  - Multiply issue is credit based: a slot is granted only if every op already
//    buffered or inside the multiplier, plus the new one, is sure of a FIFO slot.
//  - A MULT_LATENCY-bit shift register tracks which cycles expect a multiplier
//    result. Its popcount is the in-flight count.
//  - Multiplier results are buffered in a circular FIFO because the multiplier
//    cannot stall. They are merged onto the single ROB writeback port, and ALU
//    results always have priority.
//  - Flush (and reset) kill every in-flight and buffered multiply.
//
// Handshake: issueReq is a request-only signal. issueGrant is combinational in
// the same cycle, and the multiply is issued exactly in the cycles where
// issueReq & issueGrant. There is no backpressure on results. A multiplier
// result is valid whenever multOpcode != OPCODE_NOP, and an ALU result is valid
// whenever aluValid is high.
//
// Optional feature macro: MULT_WB_BYPASS_EN.
//  - Defined: an arrival that finds the FIFO empty and no ALU result goes
//    straight to writeback.
//  - Undefined: every arrival goes through the FIFO.
//
// Ports:
//  clk, rst                       clock, synchronous active-high reset
//  issueReq / issueGrant          multiply issue request / grant (comb)
//  flush                          ROB flush
//  multKill                       rst | flush, resets the multiplier stages
//  multOpcode/RobIdx/DstReg/ResL  multiplier output stage
//  aluValid/RobIdx/DstReg/Data    ALU result
//  wbValid/RobIdx/DstReg/Data     registered ROB writeback
//  wbFromMult                     registered; writeback came from the multiplier
//  fifoCount, inflight            buffered results / ops inside the multiplier
//  err                            sticky tracker mismatch or FIFO overflow
// -----------------------------------------------------------------------------
module mult_wb_sched #(
  parameter int ARCH_BITS    = 32,
  parameter int ROB_IDX_BITS = 5,
  parameter int REG_IDX_BITS = 5,
  parameter int MULT_LATENCY = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int OPCODE_BITS  = 4,
  parameter logic [OPCODE_BITS-1:0] OPCODE_NOP = '0,
  localparam int PTR_BITS = $clog2(FIFO_DEPTH),
  localparam int CNT_BITS = PTR_BITS + 1,
  localparam int INF_BITS = $clog2(MULT_LATENCY + 1) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    issueReq,
  output logic                    issueGrant,
  input  logic                    flush,
  output logic                    multKill,
  input  logic [OPCODE_BITS-1:0]  multOpcode,
  input  logic [ROB_IDX_BITS-1:0] multRobIdx,
  input  logic [REG_IDX_BITS-1:0] multDstReg,
  input  logic [ARCH_BITS-1:0]    multResL,
  input  logic                    aluValid,
  input  logic [ROB_IDX_BITS-1:0] aluRobIdx,
  input  logic [REG_IDX_BITS-1:0] aluDstReg,
  input  logic [ARCH_BITS-1:0]    aluData,
  output logic                    wbValid,
  output logic [ROB_IDX_BITS-1:0] wbRobIdx,
  output logic [REG_IDX_BITS-1:0] wbDstReg,
  output logic [ARCH_BITS-1:0]    wbData,
  output logic                    wbFromMult,
  output logic [CNT_BITS-1:0]     fifoCount,
  output logic [INF_BITS-1:0]     inflight,
  output logic                    err
);

  typedef struct packed {
    logic [ROB_IDX_BITS-1:0] rob;
    logic [REG_IDX_BITS-1:0] dst;
    logic [ARCH_BITS-1:0]    data;
  } ent_t;

  // State
  logic [MULT_LATENCY-1:0] track_q, track_d;
  logic [PTR_BITS-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_BITS-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CNT_BITS-1:0]     count_q, count_d;
  ent_t                    mem_q [FIFO_DEPTH];
  logic                    wb_valid_q, wb_valid_d;
  logic                    wb_from_mult_q, wb_from_mult_d;
  ent_t                    wb_ent_q, wb_ent_d;
  logic                    err_q, err_d;

  // Combinational helpers
  logic [INF_BITS-1:0] inflight_c;
  logic                arrival;
  logic                expect_arr;
  logic                push;
  logic                pop;
  logic                push_ok;
  logic                overflow;
  ent_t                mult_ent;
  ent_t                alu_ent;

  assign arrival    = (multOpcode != OPCODE_NOP);
  assign expect_arr = track_q[MULT_LATENCY-1];
  assign mult_ent   = '{rob: multRobIdx, dst: multDstReg, data: multResL};
  assign alu_ent    = '{rob: aluRobIdx, dst: aluDstReg, data: aluData};
  assign multKill   = rst | flush;

  always_comb begin
    inflight_c = '0;
    for (int i = 0; i < MULT_LATENCY; i++) begin
      inflight_c = inflight_c + INF_BITS'(track_q[i]);
    end
  end

  // Everything already committed to the FIFO (buffered or still in the
  // multiplier) must leave room for the new op, so no arrival can overflow.
  assign issueGrant = issueReq & ~rst & ~flush &
                      ((32'(count_q) + 32'(inflight_c)) < 32'(FIFO_DEPTH));

  always_comb begin
    track_d        = (track_q << 1) | MULT_LATENCY'(issueGrant);
    wb_valid_d     = 1'b0;
    wb_from_mult_d = 1'b0;
    wb_ent_d       = wb_ent_q;
    push           = 1'b0;
    pop            = 1'b0;
    // Each expected slot must see exactly one arrival, and vice versa.
    err_d          = err_q | (arrival ^ expect_arr);

    if (aluValid) begin
      // ALU results are written back even in a flush cycle; the ROB filters them.
      wb_valid_d = 1'b1;
      wb_ent_d   = alu_ent;
      push       = arrival & ~flush;
    end else if (flush) begin
      // Buffered and arriving multiplies are dead; nothing is written back.
    end else if (count_q != '0) begin
      pop            = 1'b1;
      wb_valid_d     = 1'b1;
      wb_from_mult_d = 1'b1;
      wb_ent_d       = mem_q[rd_ptr_q];
      push           = arrival;
    end else if (arrival) begin
`ifdef MULT_WB_BYPASS_EN
      wb_valid_d     = 1'b1;
      wb_from_mult_d = 1'b1;
      wb_ent_d       = mult_ent;
`else
      push           = 1'b1;
`endif
    end

    // Push into a full FIFO is only legal if the head leaves the same cycle.
    overflow = push & ~pop & (count_q == CNT_BITS'(FIFO_DEPTH));
    push_ok  = push & ~overflow;
    if (overflow) begin
      err_d = 1'b1;
    end

    rd_ptr_d = pop ? rd_ptr_q + PTR_BITS'(1) : rd_ptr_q;
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_BITS'(1) : wr_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + CNT_BITS'(1);
    end else if (!push_ok && pop) begin
      count_d = count_q - CNT_BITS'(1);
    end

    if (flush) begin
      track_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      track_q        <= '0;
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      count_q        <= '0;
      wb_valid_q     <= 1'b0;
      wb_from_mult_q <= 1'b0;
      wb_ent_q       <= '0;
      err_q          <= 1'b0;
    end else begin
      track_q        <= track_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      count_q        <= count_d;
      wb_valid_q     <= wb_valid_d;
      wb_from_mult_q <= wb_from_mult_d;
      wb_ent_q       <= wb_ent_d;
      err_q          <= err_d;
    end
  end

  // Storage needs no reset; the pointers and count define what is valid.
  // When the FIFO is full the write slot equals the read slot, and a same-cycle
  // push and pop reads the old head before it is overwritten.
  always_ff @(posedge clk) begin
    if (push_ok && !rst) begin
      mem_q[wr_ptr_q] <= mult_ent;
    end
  end

  assign wbValid    = wb_valid_q;
  assign wbFromMult = wb_from_mult_q;
  assign wbRobIdx   = wb_ent_q.rob;
  assign wbDstReg   = wb_ent_q.dst;
  assign wbData     = wb_ent_q.data;
  assign fifoCount  = count_q;
  assign inflight   = inflight_c;
  assign err        = err_q;

endmodule

// File: tb/tb_mult_wb_sched.sv
// Testbench for mult_wb_sched.
// - The testbench models the 4-stage multiplier itself: a granted op reappears
//   at the multiplier outputs 4 cycles later, and multKill removes every
//   pending op.
// - A queue-based reference model predicts the registered outputs, the
//   combinational grant and multKill, and the counters for every cycle.
module tb_mult_wb_sched;

  localparam int LAT   = 4;
  localparam int DEPTH = 4;
  localparam int EW    = 5 + 5 + 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issueReq = 1'b0;
  logic        flush = 1'b0;
  logic        aluValid = 1'b0;
  logic [3:0]  multOpcode = '0;
  logic [4:0]  multRobIdx = '0, multDstReg = '0, aluRobIdx = '0, aluDstReg = '0;
  logic [31:0] multResL = '0, aluData = '0;
  logic        issueGrant, multKill, wbValid, wbFromMult, err;
  logic [4:0]  wbRobIdx, wbDstReg;
  logic [31:0] wbData;
  logic [2:0]  fifoCount;
  logic [3:0]  inflight;

  mult_wb_sched dut (
    .clk(clk), .rst(rst), .issueReq(issueReq), .issueGrant(issueGrant),
    .flush(flush), .multKill(multKill), .multOpcode(multOpcode),
    .multRobIdx(multRobIdx), .multDstReg(multDstReg), .multResL(multResL),
    .aluValid(aluValid), .aluRobIdx(aluRobIdx), .aluDstReg(aluDstReg),
    .aluData(aluData), .wbValid(wbValid), .wbRobIdx(wbRobIdx),
    .wbDstReg(wbDstReg), .wbData(wbData), .wbFromMult(wbFromMult),
    .fifoCount(fifoCount), .inflight(inflight), .err(err)
  );

  // Clock
  always #5 clk = ~clk;

  // Reference model state
  typedef struct {
    int            due;
    logic [EW-1:0] ent;
  } op_t;
  op_t           pipe[$];   // ops inside the multiplier, oldest first
  logic [EW-1:0] exp_q[$];  // buffered multiply results, oldest first
  logic          e_v = 1'b0, e_m = 1'b0, e_err = 1'b0;
  logic [EW-1:0] e_fields = '0;
  logic          fields_known = 1'b0;
  logic          model_known = 1'b0;
  logic          fixed_next = 1'b0;
  int            cyc = 0;
  int            errors = 0;
  int            checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: check registered outputs, drive inputs, check the
  // combinational outputs, then advance the model across the next edge.
  task automatic step(input logic rs, input logic req, input logic av,
                      input logic fl, input logic frc);
    logic          arr;
    logic [EW-1:0] arr_ent;
    logic [EW-1:0] alu_ent;
    logic          exp_grant;
    logic [31:0]   a, b, prod;
    logic [4:0]    orob, odst;
    op_t           o;
    @(negedge clk);
    if (model_known) begin
      chk("wbValid", 64'(wbValid), 64'(e_v));
      chk("wbFromMult", 64'(wbFromMult), 64'(e_m));
      chk("err", 64'(err), 64'(e_err));
      chk("fifoCount", 64'(fifoCount), 64'(exp_q.size()));
      chk("inflight", 64'(inflight), 64'(pipe.size()));
      if (e_v || fields_known) begin
        chk("wbFields", 64'({wbRobIdx, wbDstReg, wbData}), 64'(e_fields));
      end
    end
    rst       = rs;
    issueReq  = req;
    flush     = fl;
    aluValid  = av;
    aluRobIdx = 5'($urandom);
    aluDstReg = 5'($urandom);
    aluData   = $urandom;
    alu_ent   = {aluRobIdx, aluDstReg, aluData};
    arr       = frc || (pipe.size() > 0 && pipe[0].due == cyc);
    arr_ent   = {10'($urandom), $urandom};
    if (!frc && arr) arr_ent = pipe[0].ent;
    multOpcode = arr ? 4'($urandom_range(15, 1)) : 4'd0;
    multRobIdx = arr_ent[41:37];
    multDstReg = arr_ent[36:32];
    multResL   = arr_ent[31:0];
    #1;
    exp_grant = req && !rs && !fl && ((exp_q.size() + pipe.size()) < DEPTH);
    chk("issueGrant", 64'(issueGrant), 64'(exp_grant));
    chk("multKill", 64'(multKill), 64'(rs | fl));

    // Model of the clock edge
    if (pipe.size() > 0 && pipe[0].due == cyc) void'(pipe.pop_front());
    if (rs) begin
      pipe.delete();
      exp_q.delete();
      e_v = 1'b0; e_m = 1'b0; e_err = 1'b0; e_fields = '0;
      fields_known = 1'b1;
      model_known  = 1'b1;
    end else begin
      fields_known = 1'b0;
      e_v = 1'b0;
      e_m = 1'b0;
      if (frc) e_err = 1'b1;  // result with no granted op behind it
      if (av) begin
        e_v = 1'b1;
        e_fields = alu_ent;
        if (arr && !fl) begin
          if (exp_q.size() == DEPTH) e_err = 1'b1;
          else exp_q.push_back(arr_ent);
        end
      end else if (fl) begin
        // killed: nothing written back
      end else if (exp_q.size() > 0) begin
        e_v = 1'b1;
        e_m = 1'b1;
        e_fields = exp_q.pop_front();
        if (arr) exp_q.push_back(arr_ent);
      end else if (arr) begin
`ifdef MULT_WB_BYPASS_EN
        e_v = 1'b1;
        e_m = 1'b1;
        e_fields = arr_ent;
`else
        exp_q.push_back(arr_ent);
`endif
      end
      if (fl) begin
        pipe.delete();
        exp_q.delete();
      end
      if (exp_grant) begin
        a = $urandom; b = $urandom; orob = 5'($urandom); odst = 5'($urandom);
        if (fixed_next) begin
          a = 32'd6; b = 32'd7; orob = 5'd3; odst = 5'd7;
          fixed_next = 1'b0;
        end
        prod  = a * b;
        o.due = cyc + LAT;
        o.ent = {orob, odst, prod};
        pipe.push_back(o);
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Single op: robIdx 3, dstReg 7, 6 x 7 = 42
    fixed_next = 1'b1;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(8);

    // Back-to-back with issueReq held high
    for (int i = 0; i < 14; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(8);

    // ALU priority: 4 grants, ALU busy in cycles 3..10, then drain
    for (int i = 0; i < 11; i++) step(1'b0, 1'b1, (i >= 3), 1'b0, 1'b0);
    idle(8);

    // Flush with 2 ops in flight and 2 buffered
    for (int i = 0; i < 6; i++) step(1'b0, (i < 4), (i >= 3), 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    idle(8);

    // Randomized traffic with occasional flushes
    for (int i = 0; i < 400; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 29) == 0), 1'b0);
    end
    idle(10);

    // Error detection: stray result with no grant, sticky until reset
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(5);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);

    // Full FIFO: overflow while ALU busy, then push+pop at full across wrap
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, (i >= 3), 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(8);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
